// File: rtl/uart_packet_deframer.sv
// Packet deframer: parses opcode/reserved/length header from a byte stream and
// reassembles the payload into big-endian 32-bit words tagged with opcode and last.
module uart_packet_deframer #(
    parameter logic [15:0] max_len_p = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  opcode_o,
    output logic [31:0] word_o,
    output logic        last_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        error_o
);

    typedef enum logic [2:0] {IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD} state_e;

    state_e      state_q;
    logic [7:0]  opc_q;
    logic [7:0]  len_lo_q;
    logic [13:0] words_left_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] shreg_q;
    logic [31:0] word_q;
    logic [7:0]  opcode_q;
    logic        last_q;
    logic        valid_q;
    logic        error_q;

    logic        rx_fire;
    logic [15:0] len_d;
    logic [15:0] len_m4;
    logic        len_ok;

    // Only the word-completing byte can stall, and only if the held word is not draining.
    assign rx_ready_o = (state_q != PAYLOAD) || (byte_cnt_q != 2'd3) || !valid_q || ready_i;
    assign rx_fire    = rx_valid_i && rx_ready_o;

    assign len_d  = {rx_data_i, len_lo_q};
    assign len_m4 = len_d - 16'd4;
    assign len_ok = (len_d >= 16'd8) && (len_d[1:0] == 2'b00) && (len_d <= max_len_p);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            opc_q        <= '0;
            len_lo_q     <= '0;
            words_left_q <= '0;
            byte_cnt_q   <= '0;
            shreg_q      <= '0;
            word_q       <= '0;
            opcode_q     <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            error_q <= 1'b0;
            if (valid_q && ready_i) valid_q <= 1'b0;
            if (rx_fire) begin
                case (state_q)
                    IDLE: begin
                        opc_q   <= rx_data_i;
                        state_q <= RSVD;
                    end
                    RSVD: state_q <= LEN_LO;
                    LEN_LO: begin
                        len_lo_q <= rx_data_i;
                        state_q  <= LEN_HI;
                    end
                    LEN_HI: begin
                        if (len_ok) begin
                            words_left_q <= len_m4[15:2];
                            byte_cnt_q   <= 2'd0;
                            state_q      <= PAYLOAD;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                    PAYLOAD: begin
                        shreg_q    <= {shreg_q[15:0], rx_data_i};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // A load wins over a same-cycle drain, so valid stays high.
                            word_q       <= {shreg_q, rx_data_i};
                            opcode_q     <= opc_q;
                            last_q       <= (words_left_q == 14'd1);
                            valid_q      <= 1'b1;
                            words_left_q <= words_left_q - 14'd1;
                            if (words_left_q == 14'd1) state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign word_o   = word_q;
    assign opcode_o = opcode_q;
    assign last_o   = last_q;
    assign valid_o  = valid_q;
    assign error_o  = error_q;
    assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_packet_deframer.sv
// Scoreboard bench for uart_packet_deframer: directed packets push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_uart_packet_deframer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [7:0]  opcode_o;
    logic [31:0] word_o;
    logic        last_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        error_o;

    uart_packet_deframer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .opcode_o(opcode_o), .word_o(word_o), .last_o(last_o), .valid_o(valid_o),
        .ready_i(ready_i), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] w;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every beat accepted downstream is compared against the scoreboard head.
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_ni && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got op=0x%0h word=0x%0h expected none", opcode_o, word_o);
            end else begin
                e = exp_q.pop_front();
                chk("beat_opcode", {24'd0, opcode_o}, {24'd0, e.op});
                chk("beat_word", word_o, e.w);
                chk("beat_last", {31'd0, last_o}, {31'd0, e.last});
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit ok = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk_i);
            if (rx_ready_o) begin ok = 1; break; end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL rx_timeout: byte 0x%0h not accepted, expected accept within 200 cycles", b);
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
        send(op);
        send(8'h00);
        send(len[7:0]);
        send(len[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send(w[31:24]);
        send(w[23:16]);
        send(w[15:8]);
        send(w[7:0]);
    endtask

    task automatic push(input logic [7:0] op, input logic [31:0] w, input logic last);
        beat_t e;
        e.op = op; e.w = w; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},  {31'd0, valid_o},    32'd0);
        chk({tag, "_last"},   {31'd0, last_o},     32'd0);
        chk({tag, "_error"},  {31'd0, error_o},    32'd0);
        chk({tag, "_busy"},   {31'd0, busy_o},     32'd0);
        chk({tag, "_rxrdy"},  {31'd0, rx_ready_o}, 32'd1);
        chk({tag, "_word"},   word_o,              32'd0);
        chk({tag, "_opcode"}, {24'd0, opcode_o},   32'd0);
    endtask

    task automatic drain(input int cyc);
        repeat (cyc) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        ready_i    = 1'b1;
        #3;
        chk_reset("rst0");
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Two-word packet, ready held high.
        push(8'h10, 32'h0000_0005, 1'b0);
        push(8'h10, 32'h0000_0007, 1'b1);
        send_hdr(8'h10, 16'd12);
        chk("busy_in_pkt", {31'd0, busy_o}, 32'd1);
        send_word(32'h0000_0005);
        send_word(32'h0000_0007);
        @(negedge clk_i);
        chk("busy_after_pkt", {31'd0, busy_o}, 32'd0);
        drain(2);

        // Single-word packet.
        push(8'h20, 32'hDEAD_BEEF, 1'b1);
        send_hdr(8'h20, 16'd8);
        send_word(32'hDEAD_BEEF);
        drain(3);

        // Bad length: one-cycle error pulse, no beat, then a clean packet.
        send_hdr(8'h10, 16'd6);
        @(negedge clk_i);
        chk("err_pulse", {31'd0, error_o}, 32'd1);
        chk("err_busy", {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        chk("err_clear", {31'd0, error_o}, 32'd0);
        @(posedge clk_i); #1;
        push(8'h11, 32'h0000_0001, 1'b1);
        send_hdr(8'h11, 16'd8);
        send_word(32'h0000_0001);
        drain(3);

        // Back-pressure on a 3-word packet.
        ready_i = 1'b0;
        push(8'h50, 32'hA1A2_A3A4, 1'b0);
        push(8'h50, 32'hB1B2_B3B4, 1'b0);
        push(8'h50, 32'hC1C2_C3C4, 1'b1);
        send_hdr(8'h50, 16'd16);
        send_word(32'hA1A2_A3A4);
        send(8'hB1); send(8'hB2); send(8'hB3);
        rx_data_i  = 8'hB4;
        rx_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("stall_rxrdy", {31'd0, rx_ready_o}, 32'd0);
            chk("stall_word", word_o, 32'hA1A2_A3A4);
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
        end
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        send(8'hB4);
        send_word(32'hC1C2_C3C4);
        drain(3);

        // Reset mid-payload drops everything.
        send_hdr(8'h30, 16'd8);
        send(8'hAA); send(8'hBB);
        rst_ni = 1'b0;
        #2;
        chk_reset("rst_mid");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        push(8'h30, 32'h1234_5678, 1'b1);
        send_hdr(8'h30, 16'd8);
        send_word(32'h1234_5678);
        drain(3);

        // Next header parsed while previous last word is still held.
        ready_i = 1'b0;
        push(8'h40, 32'h0102_0304, 1'b1);
        push(8'h41, 32'h0506_0708, 1'b1);
        send_hdr(8'h40, 16'd8);
        send_word(32'h0102_0304);
        send_hdr(8'h41, 16'd8);
        chk("b2b_busy", {31'd0, busy_o}, 32'd1);
        chk("b2b_held_op", {24'd0, opcode_o}, 32'h40);
        send(8'h05); send(8'h06); send(8'h07);
        ready_i = 1'b1;
        send(8'h08);
        drain(4);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/uart_packet_deframer.md
# uart_packet_deframer

Receive-side packet deframer for `uart_alu`. It consumes the byte stream from `uart_rx`'s AXI-Stream master and parses each packet header: opcode, reserved byte, 16-bit little-endian length. It then reassembles the payload into big-endian 32-bit operand words, each tagged with the opcode and a last flag, for the ALU datapath. It is the receiving counterpart of the host-side packet sender.

## Interface
- `max_len_p`, default 16'hFFFF: largest accepted length field, in bytes including the header.
- `clk_i`, input, 1: single clock. One clock; reset is asynchronous and active-low.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `rx_data_i`, input, 8: byte from `uart_rx` (`m_axis_tdata`).
- `rx_valid_i`, input, 1: byte valid.
- `rx_ready_o`, output, 1: byte accepted when `rx_valid_i & rx_ready_o`.
- `opcode_o`, output, 8: opcode of the packet owning the current word.
- `word_o`, output, 32: payload word. The first byte received is `[31:24]`.
- `last_o`, output, 1: current word is the final word of its packet.
- `valid_o`, output, 1: word beat valid.
- `ready_i`, input, 1: downstream accepts the beat when `valid_o & ready_i`.
- `busy_o`, output, 1: high whenever the state is not IDLE.
- `error_o`, output, 1: one-cycle pulse on a malformed header.

## Operation
- States: IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD.
- IDLE: on byte accept, latch the opcode, then go to RSVD.
- RSVD: accept any value, content ignored, then go to LEN_LO.
- LEN_LO: latch `len[7:0]`, then go to LEN_HI.
- LEN_HI: form `len = {byte, len[7:0]}`, then check it:
  - Valid when `len >= 8`, `len[1:0] == 0` and `len <= max_len_p`.
  - Valid: load `words_left = (len - 4) >> 2` (14 bits), clear `byte_cnt`, go to PAYLOAD.
  - Invalid: pulse `error_o`, return to IDLE. Following bytes are parsed as a new header; no resynchronisation search.
- PAYLOAD: shift each accepted byte into `shreg` (`shreg = {shreg[23:0], byte}`) and increment the 2-bit `byte_cnt`.
  - On accepting the 4th byte (`byte_cnt == 3`), load the output register:
    - `word_o = {shreg[23:0], byte}`
    - `opcode_o` = latched opcode
    - `last_o = (words_left == 1)`
    - `valid_o = 1`
  - Then decrement `words_left`. When it reaches 0, go to IDLE; otherwise stay in PAYLOAD.
- Output register is a single entry. `valid_o` clears on `ready_i` unless a new word loads in the same cycle.
- `rx_ready_o = (state != PAYLOAD) | (byte_cnt != 3) | !valid_o | ready_i`. Only the word-completing byte can be back-pressured; header bytes are never stalled.
- A new packet's header may be parsed while the previous packet's last word is still held unaccepted.
- All counter arithmetic is unsigned and wraps only by construction: `words_left` never decrements below 0.

## Timing
- Reset (asynchronous, `rst_ni` low) values:
  - state IDLE; `byte_cnt` = 0; `words_left` = 0
  - `valid_o` = 0, `last_o` = 0, `error_o` = 0
  - `word_o` = 0, `opcode_o` = 0
  - `busy_o` = 0; `rx_ready_o` = 1 (IDLE)
- Deassertion of reset is synchronised by the integrating top; the block samples no bytes in the reset cycle.
- Latency: `valid_o` rises on the clock edge after the 4th payload byte is accepted, i.e. 1 cycle.
- `error_o` is asserted for exactly the one cycle after the bad length high byte is accepted.
- Back-to-back throughput is one word per 4 byte-accept cycles, with no bubbles while `ready_i` is held high.
- Simultaneous drain and load in the same cycle: the new word replaces the old one and `valid_o` stays 1.
- `word_o`, `opcode_o` and `last_o` are stable while `valid_o & !ready_i`.
- Reset asserted mid-packet: immediately return to IDLE, drop the partial word and the held output, and `valid_o` falls asynchronously.
- `busy_o` rises the cycle after the opcode byte is accepted and falls the cycle after the final payload byte or a bad length byte.

## Test plan
- Bytes 0x10,00,0C,00,00,00,00,05,00,00,00,07 with `ready_i = 1` -> two beats:
  - `opcode_o = 0x10`, `word_o = 0x00000005`, `last_o = 0`
  - then `word_o = 0x00000007`, `last_o = 1`
  - `busy_o` low afterwards.
- Single-word packet 0x20,00,08,00,DE,AD,BE,EF -> one beat, `word_o = 0xDEADBEEF`, `last_o = 1`, `opcode_o = 0x20`.
- Length 0x0006 (bytes 0x10,00,06,00) -> `error_o` pulses one cycle, no beat; the next packet 0x11,00,08,00,00,00,00,01 yields `word_o = 1`, `opcode_o = 0x11`.
- `ready_i = 0` during a 3-word packet -> `rx_ready_o` drops on the 8th payload byte, and the first word is held stable. Raising `ready_i` drains all words in order with no loss or duplication.
- Assert `rst_ni` after 2 payload bytes -> all outputs return to their reset values. A fresh packet 0x30,00,08,00,12,34,56,78 yields `word_o = 0x12345678`.
- Back-to-back packets with the second header arriving while the first packet's last word is held -> header accepted, both opcodes correct on their respective beats.
